// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler
// Shares one interleaved multichannel FIR datapath among NCH sample sources.
// Each cycle in RUN, at most one valid channel is granted (round-robin from
// rr_ptr). The granted sample is registered to the datapath with its channel
// tag. A FIR_LATENCY-deep tag pipeline follows each sample through the
// datapath so that its result can be steered into that channel's output
// register. A drain state waits for all in-flight tags before idling.
//
// Build option: FIR_SCHED_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest-index valid channel wins, no rr_ptr
//   undefined -> round-robin (default)
//
// Ports
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_enable          level, allows granting
//   i_flush           one-cycle request to stop granting and drain
//   i_ch_valid/data   per-channel sample inputs (channel k at [k*DW +: DW])
//   o_ch_ready        one-hot or zero grant
//   o_fir_valid/data/ch  sample strobe, sample and tag to the datapath
//   i_fir_data        datapath result, FIR_LATENCY cycles after o_fir_valid
//   o_out_valid/data  per-channel result pulse and held result registers
//   o_busy            high in RUN or DRAIN
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | no grants, waits for i_enable
// RUN   | grants one sample per cycle
// DRAIN | no grants, waits until no tags are in flight

module fir_channel_scheduler #(
   parameter  int NCH         = 4,
   parameter  int DW          = 8,
   parameter  int FIR_LATENCY = 3,
   localparam int CW          = $clog2(NCH)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic              i_flush,
   input  logic [NCH-1:0]    i_ch_valid,
   input  logic [NCH*DW-1:0] i_ch_data,
   output logic [NCH-1:0]    o_ch_ready,
   output logic              o_fir_valid,
   output logic [DW-1:0]     o_fir_data,
   output logic [CW-1:0]     o_fir_ch,
   input  logic [DW-1:0]     i_fir_data,
   output logic [NCH-1:0]    o_out_valid,
   output logic [NCH*DW-1:0] o_out_data,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                 state;
   logic [FIR_LATENCY-1:0] tag_v;
   logic [CW-1:0]          tag_ch [FIR_LATENCY];
`ifndef FIR_SCHED_FIXED_PRIO_EN
   logic [CW-1:0]          rr_ptr;
`endif

   logic [NCH-1:0] grant;
   logic [CW-1:0]  grant_ch;
   logic           grant_any;
   logic           in_flight;

   // Flush and enable-low both suppress the grant in the cycle they are seen.
   always_comb begin
      int idx;
      grant     = '0;
      grant_ch  = '0;
      grant_any = 1'b0;
      idx       = 0;
      if (!i_reset && state == S_RUN && i_enable && !i_flush) begin
         for (int i = 0; i < NCH; i++) begin
`ifdef FIR_SCHED_FIXED_PRIO_EN
            idx = i;
`else
            idx = int'(rr_ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
`endif
            if (!grant_any && i_ch_valid[idx]) begin
               grant_any  = 1'b1;
               grant[idx] = 1'b1;
               grant_ch   = CW'(idx);
            end
         end
      end
   end

   assign o_ch_ready = grant;
   assign in_flight  = o_fir_valid | (|tag_v);
   assign o_busy     = (state != S_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= S_IDLE;
`ifndef FIR_SCHED_FIXED_PRIO_EN
         rr_ptr      <= '0;
`endif
         o_fir_valid <= 1'b0;
         o_fir_data  <= '0;
         o_fir_ch    <= '0;
         o_out_valid <= '0;
         o_out_data  <= '0;
         tag_v       <= '0;
         for (int i = 0; i < FIR_LATENCY; i++) tag_ch[i] <= '0;
      end else begin
         o_fir_valid <= grant_any;
         if (grant_any) begin
            o_fir_data <= i_ch_data[int'(grant_ch)*DW +: DW];
            o_fir_ch   <= grant_ch;
`ifndef FIR_SCHED_FIXED_PRIO_EN
            rr_ptr     <= (grant_ch == CW'(NCH-1)) ? '0 : grant_ch + 1'b1;
`endif
         end

         tag_v[0]  <= o_fir_valid;
         tag_ch[0] <= o_fir_ch;
         for (int i = 1; i < FIR_LATENCY; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_ch[i] <= tag_ch[i-1];
         end

         // The tag at the pipeline end lines up with i_fir_data this cycle.
         o_out_valid <= '0;
         if (tag_v[FIR_LATENCY-1]) begin
            o_out_valid[tag_ch[FIR_LATENCY-1]] <= 1'b1;
            o_out_data[int'(tag_ch[FIR_LATENCY-1])*DW +: DW] <= i_fir_data;
         end

         case (state)
            S_IDLE:  if (i_enable) state <= S_RUN;
            S_RUN:   if (i_flush || !i_enable) state <= S_DRAIN;
            S_DRAIN: if (!in_flight) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Testbench for fir_channel_scheduler: NCH=4, DW=8, FIR_LATENCY=3, datapath
// modelled as a 3-cycle delay of o_fir_data+1. The driver predicts grants
// from a behavioural model and queues the expected per-channel result with
// its due cycle; an independent monitor pops and checks every result pulse.

module tb_fir_channel_scheduler;

   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int L   = 3;
   localparam int CW  = 2;

   logic              clk = 1'b0;
   logic              i_reset, i_enable, i_flush;
   logic [NCH-1:0]    i_ch_valid;
   logic [NCH*DW-1:0] i_ch_data;
   logic [NCH-1:0]    o_ch_ready;
   logic              o_fir_valid;
   logic [DW-1:0]     o_fir_data;
   logic [CW-1:0]     o_fir_ch;
   logic [DW-1:0]     i_fir_data;
   logic [NCH-1:0]    o_out_valid;
   logic [NCH*DW-1:0] o_out_data;
   logic              o_busy;

   always #5 clk = ~clk;

   fir_channel_scheduler #(.NCH(NCH), .DW(DW), .FIR_LATENCY(L)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
      .i_ch_valid(i_ch_valid), .i_ch_data(i_ch_data), .o_ch_ready(o_ch_ready),
      .o_fir_valid(o_fir_valid), .o_fir_data(o_fir_data), .o_fir_ch(o_fir_ch),
      .i_fir_data(i_fir_data), .o_out_valid(o_out_valid),
      .o_out_data(o_out_data), .o_busy(o_busy)
   );

   // datapath model
   logic [DW-1:0] dp [L];
   always @(posedge clk) begin
      dp[0] <= o_fir_data + 8'd1;
      for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
   end
   assign i_fir_data = dp[L-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [CW-1:0] ch;
      logic [DW-1:0] data;
      logic [31:0]   due;
   } exp_t;

   exp_t          sb[$];
   int            grant_q[$];
   int            grant_log[$];
   logic [DW-1:0] m_out [NCH];
   int            m_state = 0;   // 0 idle, 1 run, 2 drain
   int            m_ptr = 0;
   logic          m_prev_grant = 1'b0;
   logic          mon_en = 1'b0;
   int            n_vec = 0;
   int            n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] packed_model();
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < NCH; i++) r[i*DW +: DW] = m_out[i];
      return r;
   endfunction

   // One clock cycle of stimulus plus model prediction.
   task automatic step(input logic rst, input logic en, input logic fl,
                       input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d);
      logic [NCH-1:0] exp_ready;
      logic [DW-1:0]  smp;
      int             k;
      int             inflight;
      exp_t           e;
      @(negedge clk);
      i_reset = rst; i_enable = en; i_flush = fl; i_ch_valid = v; i_ch_data = d;
      #1;
      k = -1;
      if (!rst && m_state == 1 && en && !fl) begin
         for (int i = 0; i < NCH; i++) begin
            int c;
`ifdef FIR_SCHED_FIXED_PRIO_EN
            c = i;
`else
            c = (m_ptr + i) % NCH;
`endif
            if (k < 0 && v[c]) k = c;
         end
      end
      exp_ready = '0;
      if (k >= 0) exp_ready[k] = 1'b1;
      chk("ready", 32'(o_ch_ready), 32'(exp_ready));
      chk("busy", 32'(o_busy), 32'(m_state != 0));
      chk("fir_valid", 32'(o_fir_valid), 32'(m_prev_grant));

      inflight = 0;
      foreach (grant_q[i])
         if (cyc - grant_q[i] >= 1 && cyc - grant_q[i] <= L + 1) inflight++;

      if (rst) begin
         m_state = 0; m_ptr = 0; m_prev_grant = 1'b0;
         grant_q.delete(); sb.delete();
         for (int i = 0; i < NCH; i++) m_out[i] = '0;
      end else begin
         m_prev_grant = (k >= 0);
         if (k >= 0) begin
            smp    = d[k*DW +: DW];
            e.ch   = CW'(k);
            e.data = smp + 8'd1;
            e.due  = 32'(cyc + L + 2);
            sb.push_back(e);
            grant_q.push_back(cyc);
            grant_log.push_back(k);
            m_ptr = (k + 1) % NCH;
         end
         case (m_state)
            0: if (en) m_state = 1;
            1: if (fl || !en) m_state = 2;
            default: if (inflight == 0) m_state = 0;
         endcase
      end
      while (grant_q.size() > 0 && cyc - grant_q[0] > L + 1) void'(grant_q.pop_front());
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (o_out_valid != '0) begin
               chk("out_onehot", 32'($countones(o_out_valid)), 32'd1);
               if (sb.size() == 0) begin
                  n_vec++; n_fail++;
                  $display("FAIL unexpected_out: got valid %0h expected none (cycle %0d)",
                           o_out_valid, cyc);
               end else begin
                  e = sb.pop_front();
                  chk("out_ch", 32'(o_out_valid), 32'(1) << e.ch);
                  chk("out_data", 32'(o_out_data[int'(e.ch)*DW +: DW]), 32'(e.data));
                  chk("out_time", 32'(cyc), e.due);
                  m_out[e.ch] = e.data;
               end
            end
            chk("out_regs", o_out_data, packed_model());
         end
      end
   end

   initial begin
      logic [NCH*DW-1:0] d0;
      int n;
      for (int i = 0; i < NCH; i++) m_out[i] = '0;
      i_reset = 1'b1; i_enable = 1'b0; i_flush = 1'b0; i_ch_valid = '0; i_ch_data = '0;
      repeat (3) @(posedge clk);
      mon_en = 1'b1;

      // reset state
      step(0, 0, 0, '0, '0);
      chk("rst_out_data", o_out_data, 32'd0);
      chk("rst_fir_data", 32'(o_fir_data), 32'd0);
      chk("rst_fir_ch", 32'(o_fir_ch), 32'd0);
      chk("rst_out_valid", 32'(o_out_valid), 32'd0);

      // all channels valid for 8 cycles
      d0 = {8'h13, 8'h12, 8'h11, 8'h10};
      step(0, 1, 0, '0, d0);
      grant_log.delete();
      repeat (8) step(0, 1, 0, 4'hF, d0);
      for (int i = 0; i < 8; i++) begin
`ifdef FIR_SCHED_FIXED_PRIO_EN
         chk("grant_order", grant_log.size() > i ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'd0);
`else
         chk("grant_order", grant_log.size() > i ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(i % 4));
`endif
      end
      repeat (6) step(0, 1, 0, '0, d0);
`ifndef FIR_SCHED_FIXED_PRIO_EN
      chk("all_ch_results", o_out_data, 32'h1413_1211);
`endif

      // only channel 2 valid
      grant_log.delete();
      repeat (3) step(0, 1, 0, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
      repeat (6) step(0, 1, 0, '0, '0);
      chk("ch2_grants", 32'(grant_log.size()), 32'd3);
      chk("ch2_result", 32'(o_out_data[2*DW +: DW]), 32'hA6);

      // flush while channel 1 is pending
      step(0, 1, 0, 4'b1000, {8'h3C, 8'h00, 8'h00, 8'h00});
      grant_log.delete();
      step(0, 1, 1, 4'b0010, {8'h00, 8'h00, 8'h77, 8'h00});
      chk("flush_no_grant", 32'(grant_log.size()), 32'd0);
      n = 0;
      repeat (8) begin
         step(0, 0, 0, 4'b0010, {8'h00, 8'h00, 8'h77, 8'h00});
         if (o_busy) n++;
      end
      chk("drain_len", 32'(n), 32'(L + 1));

      // reset with two samples in flight
      step(0, 1, 0, '0, '0);
      step(0, 1, 0, 4'b0011, {8'h00, 8'h00, 8'h22, 8'h21});
      step(0, 1, 0, 4'b0011, {8'h00, 8'h00, 8'h22, 8'h21});
      step(0, 1, 0, '0, '0);
      step(1, 1, 0, '0, '0);
      step(0, 0, 0, '0, '0);
      chk("mid_rst_out_data", o_out_data, 32'd0);
      chk("mid_rst_fir_valid", 32'(o_fir_valid), 32'd0);
      chk("mid_rst_fir_data", 32'(o_fir_data), 32'd0);
      chk("mid_rst_busy", 32'(o_busy), 32'd0);
      repeat (6) step(0, 0, 0, '0, '0);

      // enable dropped, then re-raised during the drain
      step(0, 1, 0, '0, '0);
      step(0, 1, 0, 4'hF, {8'h44, 8'h43, 8'h42, 8'h41});
      step(0, 1, 0, 4'hF, {8'h44, 8'h43, 8'h42, 8'h41});
      step(0, 0, 0, 4'hF, {8'h44, 8'h43, 8'h42, 8'h41});
      grant_log.delete();
      n = 0;
      repeat (8) begin
         step(0, 1, 0, 4'hF, {8'h44, 8'h43, 8'h42, 8'h41});
         if (!o_busy) n++;
      end
      chk("idle_gap", 32'(n), 32'd1);
`ifdef FIR_SCHED_FIXED_PRIO_EN
      chk("post_drain_grant", grant_log.size() > 0 ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd0);
`else
      chk("post_drain_grant", grant_log.size() > 0 ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd2);
`endif

      // randomized traffic
      repeat (400) begin
         step(($urandom % 100) == 0, ($urandom % 8) != 0, ($urandom % 16) == 0,
              NCH'($urandom), ($urandom));
      end

      // let everything drain, bounded
      n = 0;
      while (n < 30 && (sb.size() != 0 || m_state != 0)) begin
         step(0, 0, 0, '0, '0);
         n++;
      end
      step(0, 0, 0, '0, '0);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      chk("final_idle", 32'(o_busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_channel_scheduler.md
# fir_channel_scheduler

Round-robin scheduler that shares one interleaved multichannel FIR datapath (hsFIR family) among NCH sample sources. It accepts samples from per-channel valid/ready ports, issues at most one sample per cycle to the shared filter tagged with its channel index, and tracks each tag through the filter's fixed latency. Each filter result is steered back to the owning channel's output register. A drain state flushes in-flight samples before the block idles.

## Interface
- NCH, 4, number of requesting channels (2..16)
- DW, 8, sample width in bits, for both input and result
- FIR_LATENCY, 3, cycles from the datapath registering a sample (o_fir_valid high) to its result on i_fir_data; must be ≥1
- CW, $clog2(NCH), channel tag width (derived, not overridden)

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  level; enables granting
- i_flush  in  1  single-cycle request to stop granting and drain
- i_ch_valid  in  NCH  per-channel sample valid
- i_ch_data  in  NCH*DW  per-channel samples; channel k occupies bits [k*DW +: DW]
- o_ch_ready  out  NCH  one-hot or zero grant; a transfer occurs when valid and ready are both high
- o_fir_valid  out  1  sample-valid strobe to the datapath
- o_fir_data  out  DW  sample to the datapath
- o_fir_ch  out  CW  channel tag to the datapath, used for context selection
- i_fir_data  in  DW  datapath result, valid FIR_LATENCY cycles after the matching o_fir_valid
- o_out_valid  out  NCH  one-cycle pulse per channel when its result updates
- o_out_data  out  NCH*DW  per-channel result registers, held between updates
- o_busy  out  1  high in RUN or DRAIN

## Operation
- FSM states:
  - IDLE: no grants; moves to RUN when i_enable=1.
  - RUN: grants; moves to DRAIN when i_flush=1 or i_enable=0.
  - DRAIN: no grants; moves to IDLE when no tags are in flight.
- Grant (RUN only, combinational from i_ch_valid):
  - Search starts at pointer rr_ptr and wraps modulo NCH.
  - The first valid channel gets o_ch_ready. If no channel is valid, o_ch_ready=0.
  - Ready never asserts to a channel whose valid is low.
- On a transfer from channel k:
  - Register o_fir_data=i_ch_data[k], o_fir_ch=k, o_fir_valid=1 on the next edge.
  - rr_ptr ← (k+1) mod NCH.
  - With no transfer, o_fir_valid=0 and o_fir_data/o_fir_ch hold their values.
- Tag pipeline: a FIR_LATENCY-deep shift register of {valid, ch} is loaded from o_fir_valid/o_fir_ch.
  - When a valid tag reaches the end, o_out_data[ch] ← i_fir_data on that same edge, with a one-cycle o_out_valid[ch] pulse.
  - At most one o_out_valid bit is high per cycle.
- In-flight count equals the number of valid tags in the pipeline plus o_fir_valid. DRAIN exits when the count is 0.
- Simultaneous events:
  - i_flush during a RUN cycle suppresses that cycle's grant; flush wins.
  - i_flush in IDLE or DRAIN is ignored.
  - If i_enable returns high during DRAIN, the drain still completes; the FSM goes IDLE, then RUN on the next cycle.
- Reset, including mid-operation:
  - State → IDLE, rr_ptr=0, tag pipeline cleared, all outputs 0.
  - Results for samples in flight are discarded; no o_out_valid pulse for them after reset.

## Timing
- Handshake: transfer at edge t; o_fir_valid high in cycle t+1.
- The result is sampled from i_fir_data in cycle t+1+FIR_LATENCY; o_out_valid[k] pulses and o_out_data[k] is updated in cycle t+2+FIR_LATENCY. Total latency from acceptance is FIR_LATENCY+2 cycles.
- Throughput: one sample per cycle aggregate. Under full load each channel gets one grant every NCH cycles.
- RUN→DRAIN takes effect on the edge after i_flush. DRAIN lasts at most FIR_LATENCY+1 cycles. o_busy falls on the IDLE transition.

## Configuration
- FIR_SCHED_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest-index valid channel always wins and rr_ptr is removed.
  - Undefined (default): round-robin as specified above.
- No other behaviour changes.

## Test plan
All scenarios use NCH=4, DW=8, FIR_LATENCY=3, with the datapath modelled as a 3-cycle delay of o_fir_data+1.
- Reset, then i_enable=1 with i_ch_valid=4'b1111 held for 8 cycles, data k→8'h10+k:
  - Grants in order 0,1,2,3,0,1,2,3.
  - o_out_data[k]=8'h11+k.
  - The first o_out_valid[0] arrives 5 cycles after the first grant.
- Only channel 2 valid, data 8'hA5, for 3 cycles → three consecutive grants to channel 2; o_out_valid[2] pulses three times with 8'hA6.
- i_flush in the same cycle as a pending valid on channel 1:
  - No grant that cycle.
  - o_busy stays high for the in-flight drain, then goes low.
  - IDLE is reached within 4 cycles.
- i_reset asserted 2 cycles after two transfers → all outputs 0 on the next cycle; no o_out_valid pulses for the 2 samples.
- i_enable dropped and re-raised during DRAIN → the FSM passes through IDLE for 1 cycle; the first post-drain grant goes to the channel after the last one granted.
- With FIR_SCHED_FIXED_PRIO_EN defined and all channels valid → channel 0 is granted every cycle and channels 1–3 are starved.
